dot_product_engine: RTL and testbench

- Parametrised memory-mapped dot-product accelerator for the MIPS system.
- On a start pulse it fetches two strided vectors through a single data-memory read port and multiply-accumulates them.
- It reports the sum, a sticky overflow flag and a one-cycle done pulse.
- It extends the software inner-product workload with:
  - configurable widths and length;
  - signed/unsigned mode;
  - wrap or saturate accumulation;
  - variable-latency memory.

---
 rtl/dot_product_engine.sv | 144 ++++++++++++++
 tb/tb_dot_product_engine.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_engine.sv
// Dot-product accelerator: fetches strided A/B vectors through one read port
// and multiply-accumulates them with optional signed mode and saturation.
module dot_product_engine #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 16,
    parameter int ACC_W    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] stride,
    input  logic [LEN_W-1:0]  length,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic              overflow
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

    typedef enum logic [2:0] {IDLE, RD_A, WT_A, RD_B, WT_B, MAC, DONE} state_t;

    state_t state, state_nxt;

    logic              signed_q;
    logic [ADDR_W-1:0] stride_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [ADDR_W-1:0] ptr_a;
    logic [ADDR_W-1:0] ptr_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    logic [PROD_W-1:0]      ext_a, ext_b, prod;
    logic [SUM_W-1:0]       acc_ext, prod_ext, sum;
    logic [SUM_W-ACC_W:0]   sum_hi;
    logic                   mac_ovf;
    logic [ACC_W-1:0]       mac_result;
    logic                   last_elem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    assign last_elem = (idx == len_q - LEN_W'(1));

    // NOTE: every variable driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (length != '0) ? RD_A : DONE;
            RD_A:    state_nxt = WT_A;
            WT_A:    if (mem_rvalid) state_nxt = RD_B;
            RD_B:    state_nxt = WT_B;
            WT_B:    if (mem_rvalid) state_nxt = MAC;
            MAC:     state_nxt = last_elem ? DONE : RD_A;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sign-extending both operands lets one multiplier serve both modes; the
    // low PROD_W bits are exact for signed and unsigned products alike.
    always_comb begin
        ext_a      = {{DATA_W{signed_q & op_a[DATA_W-1]}}, op_a};
        ext_b      = {{DATA_W{signed_q & op_b[DATA_W-1]}}, op_b};
        prod       = ext_a * ext_b;
        acc_ext    = {{(SUM_W-ACC_W){signed_q & result[ACC_W-1]}}, result};
        prod_ext   = {{(SUM_W-PROD_W){signed_q & prod[PROD_W-1]}}, prod};
        sum        = acc_ext + prod_ext;
        sum_hi     = sum[SUM_W-1:ACC_W-1];
        mac_ovf    = signed_q ? !((&sum_hi) || !(|sum_hi)) : (|sum[SUM_W-1:ACC_W]);
        mac_result = sum[ACC_W-1:0];
        if (mac_ovf && SATURATE) begin
            if (!signed_q)          mac_result = '1;
            else if (sum[SUM_W-1])  mac_result = {1'b1, {(ACC_W-1){1'b0}}};
            else                    mac_result = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // Outputs are registered from the next state so they line up with it.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            signed_q <= 1'b0;
            stride_q <= '0;
            len_q    <= '0;
            idx      <= '0;
            ptr_a    <= '0;
            ptr_b    <= '0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            mem_req <= (state_nxt == RD_A) || (state_nxt == RD_B);
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == DONE);
            case (state)
                IDLE: if (start) begin
                    signed_q <= signed_mode;
                    stride_q <= stride;
                    len_q    <= length;
                    idx      <= '0;
                    ptr_a    <= base_a;
                    ptr_b    <= base_b;
                    result   <= '0;
                    overflow <= 1'b0;
                    mem_addr <= base_a;
                end
                WT_A: if (mem_rvalid) begin
                    op_a     <= mem_rdata;
                    mem_addr <= ptr_b;
                end
                WT_B: if (mem_rvalid) op_b <= mem_rdata;
                MAC: begin
                    result   <= mac_result;
                    if (mac_ovf) overflow <= 1'b1;
                    ptr_a    <= ptr_a + stride_q;
                    ptr_b    <= ptr_b + stride_q;
                    idx      <= idx + LEN_W'(1);
                    mem_addr <= ptr_a + stride_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_engine.sv
// Scoreboard bench for dot_product_engine: wrap and saturate instances share
// stimulus and a byte-addressed memory model with configurable read latency.
module tb_dot_product_engine;

    typedef struct {
        logic [31:0] res;
        logic [31:0] res_sat;
        logic        ovf;
        logic        ovf_sat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        signed_mode;
    logic [31:0] base_a, base_b, stride;
    logic [15:0] length;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    logic        mem_req, busy, done, overflow;
    logic [31:0] mem_addr, result;
    logic        sat_req, sat_busy, sat_done, sat_overflow;
    logic [31:0] sat_addr, sat_result;

    logic [31:0] mem [0:63];
    exp_t        sb[$];
    logic [31:0] exp_addr[$];
    exp_t        mon_e;
    logic [31:0] req_a, exp_a;
    int          cyc = 0;
    int          req_cnt = 0;
    int          lat = 1;
    int          dly;
    bit          rand_lat = 1'b0;
    int          n_cmp = 0;
    int          n_miss = 0;

    dot_product_engine #(.SATURATE(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
        .base_a(base_a), .base_b(base_b), .stride(stride), .length(length),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    dot_product_engine #(.SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .start(start), .signed_mode(signed_mode),
        .base_a(base_a), .base_b(base_b), .stride(stride), .length(length),
        .mem_req(sat_req), .mem_addr(sat_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .busy(sat_busy), .done(sat_done), .result(sat_result), .overflow(sat_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory responder: one outstanding read, rvalid after lat (or 1-4) edges.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                req_cnt++;
                req_a = mem_addr;
                check("sat_req", sat_req, 1'b1);
                if (exp_addr.size() == 0) begin
                    check("unexpected_req", mem_req, 1'b0);
                end else begin
                    exp_a = exp_addr.pop_front();
                    check("mem_addr", mem_addr, exp_a);
                    check("sat_mem_addr", sat_addr, exp_a);
                end
                dly = rand_lat ? int'($urandom_range(1, 4)) : lat;
                repeat (dly) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = mem[req_a[7:2]];
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
                mem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: every done pulse pops one expected response.
    always @(negedge clk) begin
        if (done === 1'b1 || sat_done === 1'b1) begin
            check("done_align", sat_done, done);
            if (sb.size() == 0) begin
                check("spurious_done", done, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("overflow", overflow, mon_e.ovf);
                check("sat_result", sat_result, mon_e.res_sat);
                check("sat_overflow", sat_overflow, mon_e.ovf_sat);
                check("busy_at_done", busy, 1'b1);
                if (mon_e.cyc >= 0) check("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (6) @(posedge clk);
        #1;
        check("req_count", exp_addr.size(), 0);
        check("idle_after", busy, 1'b0);
        exp_addr.delete();
    endtask

    task automatic run(input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] st,
                       input logic [15:0] n, input logic sm,
                       input logic [31:0] r0, input logic [31:0] r1, input logic o0, input logic o1,
                       input bit timed, input int hold, input bit poke);
        exp_t e;
        for (int i = 0; i < int'(n); i++) begin
            exp_addr.push_back(ba + st * 32'(i));
            exp_addr.push_back(bb + st * 32'(i));
        end
        @(posedge clk);
        #1;
        base_a = ba; base_b = bb; stride = st; length = n; signed_mode = sm;
        start = 1'b1;
        e.res = r0; e.res_sat = r1; e.ovf = o0; e.ovf_sat = o1;
        e.cyc = timed ? cyc + 1 + 5 * int'(n) : -1;
        sb.push_back(e);
        repeat (hold) @(posedge clk);
        #1;
        start = 1'b0;
        base_a = ~ba; base_b = ~bb; stride = 32'h100; length = 16'd9; signed_mode = ~sm;
        if (poke) begin
            repeat (6) @(posedge clk);
            #1;
            base_a = 32'h40; base_b = 32'h44; length = 16'd1; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_done();
    endtask

    task automatic load_basic();
        clear_mem();
        mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
        mem[4] = 5; mem[5] = 6; mem[6] = 7; mem[7] = 8;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; signed_mode = 1'b0;
        base_a = 32'h0; base_b = 32'h0; stride = 32'h0; length = 16'h0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_sat_result", sat_result, 32'h0);
        check("rst_sat_busy", sat_busy, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic unsigned, 1-cycle memory, done 20 edges after start.
        load_basic();
        run(32'd0, 32'd16, 32'd4, 16'd4, 1'b0, 32'd70, 32'd70, 1'b0, 1'b0, 1'b1, 1, 1'b0);

        // Mixed data with random 1-4 cycle latency.
        clear_mem();
        mem[0] = 5; mem[1] = 2; mem[2] = 34; mem[3] = 4;
        mem[4] = 567; mem[5] = 6; mem[6] = 1000; mem[7] = 0;
        rand_lat = 1'b1;
        run(32'd0, 32'd16, 32'd4, 16'd4, 1'b0, 32'd36847, 32'd36847, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        rand_lat = 1'b0;

        // Signed, stride 8: -3*4 + 7*-2 = -26.
        clear_mem();
        mem[0] = 32'hFFFF_FFFD; mem[2] = 32'd7;
        mem[8] = 32'd4;         mem[10] = 32'hFFFF_FFFE;
        run(32'd0, 32'd32, 32'd8, 16'd2, 1'b1, 32'hFFFF_FFE6, 32'hFFFF_FFE6, 1'b0, 1'b0, 1'b1, 1, 1'b0);

        // Unsigned overflow: 0xFFFF0000 + 0x20000 exceeds 32 bits.
        clear_mem();
        mem[0] = 32'h1_0000; mem[1] = 32'h1_0000;
        mem[4] = 32'hFFFF;   mem[5] = 32'h2;
        run(32'd0, 32'd16, 32'd4, 16'd2, 1'b0, 32'h0001_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1, 1'b0);

        // N=0 with start held into the DONE cycle: one done, result and overflow cleared.
        run(32'd0, 32'd16, 32'd4, 16'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 2, 1'b0);

        // Signed underflow, then accumulation continues from the wrapped/clamped value.
        clear_mem();
        mem[0] = 32'h8000_0000; mem[1] = 32'h8000_0000; mem[2] = 32'd1;
        mem[4] = 32'd1;         mem[5] = 32'd1;         mem[6] = 32'd5;
        run(32'd0, 32'd16, 32'd4, 16'd3, 1'b1, 32'd5, 32'h8000_0005, 1'b1, 1'b1, 1'b1, 1, 1'b0);

        // Start pulsed while busy is ignored.
        load_basic();
        run(32'd0, 32'd16, 32'd4, 16'd4, 1'b0, 32'd70, 32'd70, 1'b0, 1'b0, 1'b1, 1, 1'b1);

        // Reset during WT_B of element 2; the late response must be ignored.
        load_basic();
        exp_addr.push_back(32'd0); exp_addr.push_back(32'd16);
        exp_addr.push_back(32'd4); exp_addr.push_back(32'd20);
        req_cnt = 0;
        @(posedge clk);
        #1;
        base_a = 32'd0; base_b = 32'd16; stride = 32'd4; length = 16'd4; signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 100 && req_cnt < 3; i++) @(posedge clk);
        lat = 12;
        for (int i = 0; i < 100 && req_cnt < 4; i++) @(posedge clk);
        check("req_before_rst", req_cnt, 4);
        repeat (2) @(posedge clk);
        #1;
        check("busy_in_wt_b", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_mem_req", mem_req, 1'b0);
        check("async_mem_addr", mem_addr, 32'h0);
        check("async_busy", busy, 1'b0);
        check("async_done", done, 1'b0);
        check("async_result", result, 32'h0);
        check("async_overflow", overflow, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("late_rvalid_busy", busy, 1'b0);
        check("late_rvalid_req", mem_req, 1'b0);
        check("late_rvalid_result", result, 32'h0);
        check("no_done_pending", sb.size(), 0);
        lat = 1;
        exp_addr.delete();

        // Fresh run after the interrupted one.
        run(32'd0, 32'd16, 32'd4, 16'd4, 1'b0, 32'd70, 32'd70, 1'b0, 1'b0, 1'b1, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
